// File: rtl/fft_frame_loader_pkg.sv
// Shared constants and types for the fft frame loader.
package fft_frame_loader_pkg;

    localparam int FFT_DATA_W = 16;
    localparam int FFT_N_PTS  = 8;

    // Q8.8 reference values
    localparam logic signed [FFT_DATA_W-1:0] FFT_Q88_ZERO    = 16'sh0000;
    localparam logic signed [FFT_DATA_W-1:0] FFT_Q88_ONE     = 16'sh0100;
    localparam logic signed [FFT_DATA_W-1:0] FFT_Q88_NEG_ONE = 16'shFF00;

    // Hand-off sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } ho_state_t;

endpackage

// File: rtl/fft_frame_buffer.sv
// Fill side of the loader: gathers streamed samples into one 8-entry bank,
// realigns on start-of-frame and flags the bank full for hand-off.
module fft_frame_buffer
    import fft_frame_loader_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int N_PTS  = FFT_N_PTS
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          s_valid,
    input  logic                          s_sof,
    input  logic [DATA_W-1:0]             s_real,
    input  logic [DATA_W-1:0]             s_imag,
    input  logic                          clr_full,
    output logic                          s_ready,
    output logic                          full,
    output logic                          sof_err,
    output logic [N_PTS-1:0][DATA_W-1:0]  bank_real,
    output logic [N_PTS-1:0][DATA_W-1:0]  bank_imag
);

    localparam int CNT_W = $clog2(N_PTS);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] widx;
    logic             accept;

    // Held low during reset so upstream never sees a stale ready.
    assign s_ready = !full && !RST;
    assign accept  = s_valid && s_ready;
    // A start-of-frame sample always lands in slot 0.
    assign widx    = s_sof ? '0 : cnt;

    // Fill counter, full flag and mid-frame sof detection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt     <= '0;
            full    <= 1'b0;
            sof_err <= 1'b0;
        end else begin
            sof_err <= 1'b0;
            if (clr_full)
                full <= 1'b0;
            if (accept) begin
                if (s_sof) begin
                    cnt     <= CNT_W'(1);
                    sof_err <= (cnt != '0);
                end else if (cnt == CNT_W'(N_PTS - 1)) begin
                    cnt  <= '0;
                    full <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Sample storage; only read once a complete frame has been written.
    always_ff @(posedge CLK) begin
        if (accept) begin
            bank_real[widx] <= s_real;
            bank_imag[widx] <= s_imag;
        end
    end

endmodule

// File: rtl/fft_frame_loader.sv
// Feeds complete 8-sample frames to the parallel fft: copies the fill bank into
// stable output registers, then sequences write/start and waits for fft ready.
module fft_frame_loader
    import fft_frame_loader_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int N_PTS  = FFT_N_PTS
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_sof,
    input  logic [DATA_W-1:0] s_real,
    input  logic [DATA_W-1:0] s_imag,
    output logic              fft_write,
    output logic              fft_start,
    input  logic              fft_ready,
    output logic [DATA_W-1:0] in0_real,
    output logic [DATA_W-1:0] in0_imag,
    output logic [DATA_W-1:0] in1_real,
    output logic [DATA_W-1:0] in1_imag,
    output logic [DATA_W-1:0] in2_real,
    output logic [DATA_W-1:0] in2_imag,
    output logic [DATA_W-1:0] in3_real,
    output logic [DATA_W-1:0] in3_imag,
    output logic [DATA_W-1:0] in4_real,
    output logic [DATA_W-1:0] in4_imag,
    output logic [DATA_W-1:0] in5_real,
    output logic [DATA_W-1:0] in5_imag,
    output logic [DATA_W-1:0] in6_real,
    output logic [DATA_W-1:0] in6_imag,
    output logic [DATA_W-1:0] in7_real,
    output logic [DATA_W-1:0] in7_imag,
    output logic              frame_done,
    output logic              sof_err,
    output logic [15:0]       frame_cnt
);

    logic                         full;
    logic                         load_out;
    logic                         done_evt;
    logic                         ready_q;
    logic [N_PTS-1:0][DATA_W-1:0] bank_real;
    logic [N_PTS-1:0][DATA_W-1:0] bank_imag;
    logic [N_PTS-1:0][DATA_W-1:0] out_re;
    logic [N_PTS-1:0][DATA_W-1:0] out_im;
    ho_state_t                    state;
    ho_state_t                    state_nxt;

    fft_frame_buffer #(
        .DATA_W (DATA_W),
        .N_PTS  (N_PTS)
    ) u_buf (
        .CLK       (CLK),
        .RST       (RST),
        .s_valid   (s_valid),
        .s_sof     (s_sof),
        .s_real    (s_real),
        .s_imag    (s_imag),
        .clr_full  (load_out),
        .s_ready   (s_ready),
        .full      (full),
        .sof_err   (sof_err),
        .bank_real (bank_real),
        .bank_imag (bank_imag)
    );

    // Hand-off state register.
    always_ff @(posedge CLK) begin
        if (RST)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next state and fft controls; write is held for the whole hand-off so the
    // fft sees stable inputs, and is forced low while reset is asserted.
    always_comb begin
        state_nxt = state;
        load_out  = 1'b0;
        done_evt  = 1'b0;
        fft_write = 1'b0;
        fft_start = 1'b0;
        if (!RST) begin
            case (state)
                ST_IDLE: begin
                    if (full) begin
                        load_out  = 1'b1;
                        state_nxt = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    fft_write = 1'b1;
                    state_nxt = ST_START;
                end
                ST_START: begin
                    fft_write = 1'b1;
                    fft_start = 1'b1;
                    state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    fft_write = 1'b1;
                    if (fft_ready && !ready_q) begin
                        done_evt  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output frame registers, ready edge tracking and completion counting.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_re     <= '0;
            out_im     <= '0;
            ready_q    <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            ready_q    <= fft_ready;
            frame_done <= done_evt;
            if (done_evt)
                frame_cnt <= frame_cnt + 16'd1;
            if (load_out) begin
                out_re <= bank_real;
                out_im <= bank_imag;
            end
        end
    end

    assign in0_real = out_re[0];
    assign in0_imag = out_im[0];
    assign in1_real = out_re[1];
    assign in1_imag = out_im[1];
    assign in2_real = out_re[2];
    assign in2_imag = out_im[2];
    assign in3_real = out_re[3];
    assign in3_imag = out_im[3];
    assign in4_real = out_re[4];
    assign in4_imag = out_im[4];
    assign in5_real = out_re[5];
    assign in5_imag = out_im[5];
    assign in6_real = out_re[6];
    assign in6_imag = out_im[6];
    assign in7_real = out_re[7];
    assign in7_imag = out_im[7];

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: directed stimulus, a scoreboard of expected
// frames, and a stub fft that raises ready a programmable delay after start.
module tb_fft_frame_loader;
    import fft_frame_loader_pkg::*;

    typedef logic [7:0][31:0] frame_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_sof = 1'b0;
    logic [15:0] s_real = '0;
    logic [15:0] s_imag = '0;
    logic        fft_ready = 1'b0;
    logic        s_ready, fft_write, fft_start, frame_done, sof_err;
    logic [15:0] frame_cnt;
    logic [15:0] in0_real, in0_imag, in1_real, in1_imag, in2_real, in2_imag, in3_real, in3_imag;
    logic [15:0] in4_real, in4_imag, in5_real, in5_imag, in6_real, in6_imag, in7_real, in7_imag;
    logic [15:0] o_re [8];
    logic [15:0] o_im [8];

    int checks = 0;
    int errors = 0;
    int stalls = 0;

    // stub fft and monitor state
    bit     stub_en = 1'b1;
    bit     force_rdy = 1'b0;
    int     stub_delay = 20;
    int     stub_cnt = 0;
    frame_t sb[$];
    frame_t mbank;
    frame_t cur;
    int     mcnt = 0;
    bit     mfull = 1'b0;
    bit     exp_sof = 1'b0;
    bit     exp_done = 1'b0;
    bit     prev_rdy = 1'b0;
    bit     prev_write = 1'b0;
    bit     rst_prev = 1'b0;
    int     wcyc = 0;
    int     exp_cnt = 0;

    always #5 CLK = ~CLK;

    fft_frame_loader dut (
        .CLK(CLK), .RST(RST), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
        .s_real(s_real), .s_imag(s_imag), .fft_write(fft_write), .fft_start(fft_start),
        .fft_ready(fft_ready),
        .in0_real(in0_real), .in0_imag(in0_imag), .in1_real(in1_real), .in1_imag(in1_imag),
        .in2_real(in2_real), .in2_imag(in2_imag), .in3_real(in3_real), .in3_imag(in3_imag),
        .in4_real(in4_real), .in4_imag(in4_imag), .in5_real(in5_real), .in5_imag(in5_imag),
        .in6_real(in6_real), .in6_imag(in6_imag), .in7_real(in7_real), .in7_imag(in7_imag),
        .frame_done(frame_done), .sof_err(sof_err), .frame_cnt(frame_cnt)
    );

    assign o_re[0] = in0_real; assign o_im[0] = in0_imag;
    assign o_re[1] = in1_real; assign o_im[1] = in1_imag;
    assign o_re[2] = in2_real; assign o_im[2] = in2_imag;
    assign o_re[3] = in3_real; assign o_im[3] = in3_imag;
    assign o_re[4] = in4_real; assign o_im[4] = in4_imag;
    assign o_re[5] = in5_real; assign o_im[5] = in5_imag;
    assign o_re[6] = in6_real; assign o_im[6] = in6_imag;
    assign o_re[7] = in7_real; assign o_im[7] = in7_imag;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stub fft: drops ready on start, raises it stub_delay cycles later.
    task automatic stub_loop();
        forever begin
            @(posedge CLK);
            #1;
            if (!stub_en) begin
                fft_ready = force_rdy;
            end else if (fft_start) begin
                fft_ready = 1'b0;
                stub_cnt  = stub_delay;
            end else if (!fft_write) begin
                stub_cnt = 0;
            end else if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) fft_ready = 1'b1;
            end
        end
    endtask

    // Monitor: checks every cycle against the fill/hand-off model and scoreboard.
    task automatic monitor();
        forever begin
            @(negedge CLK);
            if (rst_prev) begin
                chk("rst_write", fft_write, 0);
                chk("rst_start", fft_start, 0);
                chk("rst_done", frame_done, 0);
                chk("rst_sof_err", sof_err, 0);
                chk("rst_frame_cnt", frame_cnt, 0);
                for (int k = 0; k < 8; k++) chk("rst_out", {o_re[k], o_im[k]}, 0);
                prev_write = 1'b0;
                wcyc = 0;
            end else begin
                chk("sof_err", sof_err, exp_sof);
                chk("frame_done", frame_done, exp_done);
                if (frame_done) begin
                    exp_cnt++;
                    chk("done_write_low", fft_write, 0);
                end
                chk("frame_cnt", frame_cnt, 16'(exp_cnt));
                if (fft_write && !prev_write) begin
                    checks++;
                    assert (sb.size() > 0) else begin
                        errors++;
                        $error("FAIL sb_underflow: got write with %0d queued expected >0", sb.size());
                    end
                    if (sb.size() > 0) cur = sb.pop_front();
                    mfull = 1'b0;
                    wcyc  = 0;
                end else if (fft_write) begin
                    wcyc++;
                end
                if (fft_write)
                    for (int k = 0; k < 8; k++) chk("out_data", {o_re[k], o_im[k]}, cur[k]);
                chk("fft_start", fft_start, fft_write && wcyc == 1);
                prev_write = fft_write;
            end
            chk("s_ready", s_ready, !RST && !mfull);
            if (RST) begin
                mcnt = 0; mfull = 1'b0; sb.delete();
                exp_sof = 1'b0; exp_done = 1'b0; exp_cnt = 0; prev_rdy = 1'b0;
                rst_prev = 1'b1;
            end else begin
                exp_done = fft_write && wcyc >= 2 && fft_ready && !prev_rdy;
                prev_rdy = fft_ready;
                exp_sof  = 1'b0;
                if (s_valid && !mfull) begin
                    if (s_sof) begin
                        exp_sof  = (mcnt != 0);
                        mbank[0] = {s_real, s_imag};
                        mcnt     = 1;
                    end else begin
                        mbank[mcnt] = {s_real, s_imag};
                        if (mcnt == 7) begin
                            sb.push_back(mbank);
                            mfull = 1'b1;
                            mcnt  = 0;
                        end else begin
                            mcnt++;
                        end
                    end
                end
                rst_prev = 1'b0;
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Offer one sample and hold it until accepted (bounded).
    task automatic send(input logic [15:0] re, input logic [15:0] im, input logic sof);
        logic rdy;
        int   n;
        n = 0;
        s_valid = 1'b1; s_real = re; s_imag = im; s_sof = sof;
        do begin
            @(negedge CLK);
            rdy = s_ready;
            @(posedge CLK);
            #1;
            n++;
            if (!rdy) stalls++;
        end while (!rdy && n < 200);
        chk("send_accept", rdy, 1);
        s_valid = 1'b0; s_sof = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!frame_done && n < limit);
        chk("done_seen", frame_done, 1);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        fork
            stub_loop();
            monitor();
        join_none

        // reset
        cyc(2);
        RST = 1'b0;
        @(negedge CLK);
        chk("ready_after_rst", s_ready, 1);
        cyc(1);

        // frame A: ramp with sof on first, check hand-off latency
        stub_delay = 20;
        for (int i = 0; i < 8; i++) send(16'(i * 256), 16'h0000, i == 0);
        @(negedge CLK);
        chk("lat_e0_write", fft_write, 0);
        chk("lat_e0_ready", s_ready, 0);
        @(negedge CLK);
        chk("lat_e1_write", fft_write, 1);
        chk("lat_e1_start", fft_start, 0);
        chk("lat_e1_in7", in7_real, 16'h0700);
        chk("lat_e1_ready", s_ready, 1);
        @(negedge CLK);
        chk("lat_e2_start", fft_start, 1);
        @(negedge CLK);
        chk("lat_e3_start", fft_start, 0);
        chk("lat_e3_write", fft_write, 1);
        wait_done(100);
        chk("a_frame_cnt", frame_cnt, 1);

        // two frames back to back while the fft is slow
        stub_delay = 30;
        for (int i = 0; i < 16; i++) send(16'(16'h0800 + i * 256), 16'(i + 1), i == 0 || i == 8);
        @(negedge CLK);
        chk("b2b_stall", s_ready, 0);
        chk("b2b_cnt", frame_cnt, 1);
        wait_done(100);
        chk("b2b_cnt2", frame_cnt, 2);
        wait_done(100);
        chk("b2b_cnt3", frame_cnt, 3);
        chk("b2b_in0", in0_real, 16'h1000);

        // sof realign on the 4th sample
        stub_delay = 10;
        for (int i = 0; i < 3; i++) send(16'(i * 256), 16'h0010, i == 0);
        send(16'h0300, 16'h0013, 1'b1);
        @(negedge CLK);
        chk("sof_err_pulse", sof_err, 1);
        cyc(1);
        for (int i = 4; i < 11; i++) send(16'(i * 256), 16'(16'h0010 + i), 1'b0);
        wait_done(100);
        chk("sof_cnt", frame_cnt, 4);
        chk("sof_in0", in0_real, 16'h0300);

        // reset during WAIT
        stub_delay = 40;
        for (int i = 0; i < 8; i++) send(16'(16'h2000 + i * 256), 16'h0001, i == 0);
        cyc(6);
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        @(negedge CLK);
        chk("rstw_write", fft_write, 0);
        chk("rstw_cnt", frame_cnt, 0);
        chk("rstw_in0", in0_real, 0);
        cyc(1);

        // reset with a partial frame of five
        for (int i = 0; i < 5; i++) send(16'(16'h2800 + i * 256), 16'h0002, i == 0);
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        cyc(1);
        stub_delay = 10;
        for (int i = 0; i < 8; i++) send(16'(16'h3000 + i * 256), 16'(16'h0040 + i), 1'b0);
        wait_done(100);
        chk("rstp_cnt", frame_cnt, 1);
        chk("rstp_in0", in0_real, 16'h3000);
        chk("rstp_in7i", in7_imag, 16'h0047);

        // fft_ready toggling while idle is ignored
        force_rdy = 1'b0;
        stub_en   = 1'b0;
        cyc(2);
        force_rdy = 1'b1; cyc(3);
        force_rdy = 1'b0; cyc(2);
        force_rdy = 1'b1; cyc(2);
        force_rdy = 1'b0; cyc(2);
        @(negedge CLK);
        chk("idle_done", frame_done, 0);
        chk("idle_cnt", frame_cnt, 1);
        cyc(1);
        stub_en = 1'b1;

        // negative samples pass through untouched
        stub_delay = 12;
        for (int i = 0; i < 8; i++) send(16'(FFT_Q88_NEG_ONE - 16'(i * 256)), 16'(16'h8001 + i), i == 0);
        wait_done(100);
        chk("neg_cnt", frame_cnt, 2);
        chk("neg_in0", in0_real, 16'hFF00);
        chk("neg_in7", in7_real, 16'hF800);
        chk("neg_in7i", in7_imag, 16'h8008);
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
